// File: rtl/shift_seq_4_bit_if.sv
// Request/response bundle between the ALU controller (master) and the
// multi-cycle shift sequencer (slave).
// Optional feature macro: ROTATE_EN adds the 'rotate' request bit.
interface shift_seq_4_bit_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  // Request side, driven by the controller
  logic             start;
  logic [WIDTH-1:0] operand;
  logic [CNT_W-1:0] amount;
  logic             select;
  logic             ar_select;
  logic             fill_in;
`ifdef ROTATE_EN
  logic             rotate;
`endif

  // Response side, driven by the sequencer
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

`ifdef ROTATE_EN
  modport master (
    output start, operand, amount, select, ar_select, fill_in, rotate,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, operand, amount, select, ar_select, fill_in, rotate,
    output busy, done, result, carry, zero
  );
`else
  modport master (
    output start, operand, amount, select, ar_select, fill_in,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, operand, amount, select, ar_select, fill_in,
    output busy, done, result, carry, zero
  );
`endif
endinterface

// File: rtl/shift_seq_4_bit.sv
// Multi-cycle shift sequencer: loads an operand and applies one single-bit
// shift step per clock for 'amount' steps, then reports the final word, the
// last bit shifted out and a one-cycle done pulse.
// Optional feature macro: ROTATE_EN (rotate mode, fill = bit shifted out).
// Timing: with start seen in cycle 0, done is high in cycle amount+1.
module shift_seq_4_bit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_4_bit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             dir_q,    dir_d;
  logic             ar_q,     ar_d;
  logic             fill_q,   fill_d;
  logic             rot_q,    rot_d;
  logic             cy_q,     cy_d;     // working carry, last bit shifted out

  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             zero_q,   zero_d;

  logic             rotate_in;
  logic [WIDTH-1:0] step_word;
  logic             step_out;
  logic             step_fill;

`ifdef ROTATE_EN
  assign rotate_in = bus.rotate;
`else
  assign rotate_in = 1'b0;
`endif

  // One shift step of the working register using the captured mode bits
  always_comb begin
    step_out  = dir_q ? work_q[0] : work_q[WIDTH-1];
    step_fill = rot_q ? step_out : fill_q;
    if (dir_q) begin
      step_word = {step_fill, work_q[WIDTH-1:1]};
    end else begin
      step_word = {work_q[WIDTH-2:0], step_fill};
    end
    // Arithmetic mode keeps the sign bit in both directions; rotate overrides it
    if (ar_q && !rot_q) begin
      step_word[WIDTH-1] = work_q[WIDTH-1];
    end
  end

  // Next-state and next-output computation for the sequencer
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    ar_d     = ar_q;
    fill_d   = fill_q;
    rot_d    = rot_q;
    cy_d     = cy_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.operand;
          cnt_d   = bus.amount;
          dir_d   = bus.select;
          ar_d    = bus.ar_select;
          fill_d  = bus.fill_in;
          rot_d   = rotate_in;
          cy_d    = 1'b0;
          state_d = (bus.amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_d = step_word;
        cy_d   = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered against the state being entered so they line
    // up with it: busy tracks non-IDLE, done/result/carry/zero with DONE.
    busy_d = (state_d != IDLE);
    if (state_d == DONE) begin
      done_d   = 1'b1;
      result_d = work_d;
      carry_d  = cy_d;
      zero_d   = (work_d == '0);
    end
  end

  // State, datapath and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      ar_q     <= 1'b0;
      fill_q   <= 1'b0;
      rot_q    <= 1'b0;
      cy_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      ar_q     <= ar_d;
      fill_q   <= fill_d;
      rot_q    <= rot_d;
      cy_q     <= cy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;

endmodule

// File: doc/shift_seq_4_bit.md
Name: shift_seq_4_bit

Overview:
Multi-cycle shift sequencer that sits directly upstream of the 4-bit single-step shifter stage. It loads an operand and applies that shifter's one-bit step repeatedly, one step per clock, for a requested count. Each step uses left or right direction, logical or arithmetic (MSB-hold) mode, and a serial fill bit. It returns the final word, the last bit shifted out, and a done pulse to the ALU controller.

Parameters:
WIDTH, 4, operand/result width in bits; the bench is exercised at 4.
CNT_W, 3, width of the shift-amount field; maximum count is 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
operand  input  WIDTH  word to shift; captured on an accepted start.
amount  input  CNT_W  number of one-bit steps; captured on an accepted start.
select  input  1  direction: 0 = shift left, 1 = shift right; captured on start.
ar_select  input  1  1 = arithmetic, MSB retains its value every step; captured on start.
fill_in  input  1  serial fill bit: enters bit 0 on a left shift, bit WIDTH-1 on a right shift; captured on start.
busy  output  1  high while not in IDLE.
done  output  1  one-cycle pulse; result and carry are valid.
result  output  WIDTH  shifted word; held until the next accepted start.
carry  output  1  last bit shifted out; 0 if amount = 0.
zero  output  1  result == 0; registered together with result.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; busy, done, result, carry, zero all 0. Reset wins over every other input, including mid-operation. An in-flight shift is discarded and no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE with start = 1:
  - capture operand into the working register, amount into the counter, and select/ar_select/fill_in into mode registers;
  - clear carry;
  - go to SHIFT if amount != 0, else go to DONE.
- IDLE with start = 0: stay in IDLE, outputs hold.
- SHIFT: one step per cycle, with D = working register:
  - Left step: new[0] = fill; new[i] = D[i-1]; carry = D[WIDTH-1].
  - Right step: new[WIDTH-1] = fill; new[i] = D[i+1]; carry = D[0].
  - Arithmetic (ar_select = 1): new[WIDTH-1] = D[WIDTH-1] in BOTH directions, overriding the above. The carry rule is unchanged.
  - Decrement the counter; when it reaches 0 after a step, go to DONE.
- DONE:
  - drive done = 1 for exactly one cycle;
  - result = working register; zero = (result == 0); carry holds the last shifted-out bit;
  - go to IDLE.
- Latency: accepted start at edge k means done is high in the cycle after edge k+N+1, where N = amount. For N = 0 that is 1 cycle after the start edge, with result = operand and carry = 0.
- busy = 1 in SHIFT and DONE.
- start while busy is ignored; there is no queueing.
- start on the same cycle done is high is ignored, because the FSM is not in IDLE. It is accepted on the next cycle.
- amount > WIDTH is legal: steps continue, logical modes fill entirely with fill_in, arithmetic mode saturates to MSB copies.
- Changes to select/ar_select/fill_in while busy have no effect.
- result/carry/zero update only in DONE (and on reset).

Optional Feature:
ROTATE_EN:
- Defined: adds input port rotate (1 bit, captured on start).
  - When rotate = 1, the fill bit for each step is the bit being shifted out (D[WIDTH-1] for left, D[0] for right) instead of fill_in.
  - ar_select is ignored when rotate = 1.
  - carry = last bit rotated out.
- Undefined: no rotate port; the fill is always the captured fill_in.

Test Plan:
- operand=4'b1011, amount=1, select=0, ar=0, fill=0 -> done 2 cycles after start, result=4'b0110, carry=1, zero=0.
- operand=4'b1011, amount=2, select=1, ar=0, fill=0 -> result=4'b0010, carry=1; busy high 3 cycles.
- operand=4'b1000, amount=3, select=1, ar=1 -> result=4'b1111, carry=0.
- operand=4'b1011, amount=1, select=0, ar=1, fill=0 -> result=4'b1110, carry=1.
- Boundary checks:
  - amount=0, operand=4'b0101 -> done 1 cycle after start, result=4'b0101, carry=0;
  - operand=4'b0001, amount=1, select=1, fill=0 -> result=0, zero=1.
- Interference and reset:
  - start again while busy, with a different operand -> ignored, first result returned;
  - reset asserted mid-SHIFT -> next cycle busy=0, result=0, no done pulse.
  - With ROTATE_EN: operand=4'b1001, amount=1, select=1, rotate=1 -> result=4'b1100, carry=1.
